// File: rtl/montgomery_r2_precomp.sv
// Precomputes r_red = R^2 mod m with R = 2^m_size by serial modular doubling.
// One doubling step per clock. done_irq_p is the start strobe for the downstream conversion chain.
module montgomery_r2_precomp #(
  parameter int NBITS = 2048,
  parameter int PBITS = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable_p,
  input  logic [NBITS-1:0]           m,
  input  logic [$clog2(NBITS)+2:0]   m_size,
  output logic [NBITS-1:0]           r_red,
  output logic                       busy,
  output logic                       err,
  output logic                       done_irq_p
);

  localparam int MSW = $clog2(NBITS) + 3;
  localparam int CW  = $clog2(NBITS) + 2;
  localparam logic [MSW-1:0]   MAX_SIZE = MSW'(NBITS);
  localparam logic [NBITS-1:0] M_ONE    = NBITS'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [NBITS-1:0] m_lat;
  logic [NBITS-1:0] x;
  logic [CW-1:0]    count;
  logic             reject;

  logic             req_bad;
  logic [NBITS:0]   d;
  logic [NBITS-1:0] diff;
  logic [NBITS-1:0] x_dbl;

  // PBITS only has to be a sane digit width; the datapath itself is bit-serial.
  always_comb begin
    req_bad = ~m[0] | (m_size == '0) | (m_size > MAX_SIZE) | (PBITS < 1);
  end

  // x < m keeps d < 2m, so one conditional subtract restores x < m.
  // The low NBITS of the difference are exact whenever d >= m.
  always_comb begin
    d     = {x, 1'b0};
    diff  = d[NBITS-1:0] - m_lat;
    x_dbl = (d >= {1'b0, m_lat}) ? diff : d[NBITS-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable_p) state_nxt = req_bad ? DONE : RUN;
      RUN:     if (count == CW'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lat      <= '0;
      x          <= '0;
      count      <= '0;
      reject     <= 1'b0;
      r_red      <= '0;
      busy       <= 1'b0;
      err        <= 1'b0;
      done_irq_p <= 1'b0;
    end else begin
      done_irq_p <= 1'b0;
      case (state)
        IDLE: begin
          if (enable_p) begin
            m_lat  <= m;
            reject <= req_bad;
            if (req_bad) begin
              x <= '0;
            end else begin
              x     <= (m == M_ONE) ? '0 : M_ONE;
              count <= CW'({m_size, 1'b0});
              busy  <= 1'b1;
              err   <= 1'b0;
            end
          end
        end
        RUN: begin
          x     <= x_dbl;
          count <= count - CW'(1);
        end
        DONE: begin
          r_red      <= x;
          done_irq_p <= 1'b1;
          busy       <= 1'b0;
          err        <= reject;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_r2_precomp.sv
// Scoreboard bench for montgomery_r2_precomp: the driver queues expected results,
// a negedge monitor checks every done_irq_p against the queue head (value, err, cycle).
module tb_montgomery_r2_precomp;

  localparam int NB  = 32;
  localparam int MSW = $clog2(NB) + 3;

  logic              clk;
  logic              rst;
  logic              enable_p;
  logic [NB-1:0]     m;
  logic [MSW-1:0]    m_size;
  logic [NB-1:0]     r_red;
  logic              busy;
  logic              err;
  logic              done_irq_p;

  montgomery_r2_precomp #(.NBITS(NB), .PBITS(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable_p   (enable_p),
    .m          (m),
    .m_size     (m_size),
    .r_red      (r_red),
    .busy       (busy),
    .err        (err),
    .done_irq_p (done_irq_p)
  );

  typedef struct {
    logic [NB-1:0] r;
    logic          e;
    int            at;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every completion pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done_irq_p) begin
      if (q.size() == 0) begin
        check("unexpected_done", 64'(done_irq_p), 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("r_red", 64'(r_red), 64'(e.r));
        check("err", 64'(err), 64'(e.e));
        check("done_cycle", 64'(cyc), 64'(e.at));
      end
    end
  end

  // Called just after a negedge; enable_p is sampled on the following posedge.
  task automatic issue(input logic [NB-1:0] mv, input int ms, input int lat,
                       input logic [NB-1:0] er, input logic ee, input bit push);
    exp_t e;
    m        = mv;
    m_size   = MSW'(ms);
    enable_p = 1'b1;
    if (push) begin
      e.r  = er;
      e.e  = ee;
      e.at = cyc + 1 + lat;
      q.push_back(e);
    end
    @(negedge clk);
    enable_p = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      check("done_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    bit busy_ok;
    int n;

    rst      = 1'b1;
    enable_p = 1'b0;
    m        = '0;
    m_size   = '0;
    repeat (2) @(negedge clk);
    check("rst_r_red", 64'(r_red), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_done", 64'(done_irq_p), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 2^8 mod 13 = 9, 2^16 mod 241 = 225
    issue(32'd13, 4, 9, 32'd9, 1'b0, 1'b1);
    wait_idle();
    issue(32'd241, 8, 17, 32'd225, 1'b0, 1'b1);
    wait_idle();

    // 2^64 mod (2^32-1) = 1, busy must stay high for the whole run
    issue(32'hFFFF_FFFF, NB, 2 * NB + 1, 32'd1, 1'b0, 1'b1);
    busy_ok = 1'b1;
    for (int i = 0; i <= 2 * NB; i++) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
    end
    check("busy_during_run", 64'(busy_ok), 64'd1);
    check("busy_after_done", 64'(busy), 64'd0);
    wait_idle();

    // Rejected requests
    issue(32'd12, 4, 1, 32'd0, 1'b1, 1'b1);
    wait_idle();
    issue(32'd13, 0, 1, 32'd0, 1'b1, 1'b1);
    wait_idle();
    issue(32'd13, NB + 1, 1, 32'd0, 1'b1, 1'b1);
    wait_idle();

    // m = 1 keeps the full latency and yields 0
    issue(32'd1, 1, 3, 32'd0, 1'b0, 1'b1);
    wait_idle();

    // Second pulse while busy is ignored; inputs changed after start are ignored
    issue(32'd13, 4, 9, 32'd9, 1'b0, 1'b1);
    @(negedge clk);
    issue(32'd241, 8, 17, 32'd225, 1'b0, 1'b0);
    wait_idle();

    // Reset during a run: outputs return to 0 and no completion follows
    issue(32'd241, 8, 17, 32'd225, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_r_red", 64'(r_red), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_err", 64'(err), 64'd0);
    check("abort_done", 64'(done_irq_p), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);

    // Back-to-back: restart in the cycle right after done_irq_p
    issue(32'd13, 4, 9, 32'd9, 1'b0, 1'b1);
    n = 0;
    while (!done_irq_p && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!done_irq_p) check("b2b_first_done", 64'(done_irq_p), 64'd1);
    issue(32'd241, 8, 17, 32'd225, 1'b0, 1'b1);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
